// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Purpose : Shared constants for the MIPS datapath register-file slice.
// Contents: default data/address widths and the architecturally fixed
//           register numbers (r0 hard-wired zero, r31 link register for jal).
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [DEF_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
// Purpose : HI/LO special registers used by mult/multu/div/divu/mthi/mtlo.
//           Two independent registers, each with its own write enable and a
//           one-cycle write latency. Outputs always show stored contents.
// Ports   :
//   clk     in   system clock, rising-edge updates
//   rst_n   in   asynchronous active-low reset, clears both registers
//   hi_we   in   HI write enable
//   lo_we   in   LO write enable
//   hi_in   in   HI write data
//   lo_in   in   LO write data
//   hi_out  out  stored HI value
//   lo_out  out  stored LO value
// -----------------------------------------------------------------------------
module hilo_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (hi_we) begin
            hi_q <= hi_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
        end else if (lo_we) begin
            lo_q <= lo_in;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule : hilo_reg

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// Purpose : MIPS general-purpose register file (2**ADDR_W x DATA_W) with two
//           combinational read ports, one synchronous write port and the
//           HI/LO pair. r0 is hard-wired to zero. With BYPASS=1 a write in
//           flight is forwarded to a read port addressing the same register.
// Ports   :
//   clk     in   system clock, rising-edge updates
//   rst_n   in   asynchronous active-low reset, clears GPRs, HI and LO
//   we      in   GPR write enable
//   waddr   in   GPR write address (destination-select mux output)
//   wdata   in   GPR write data
//   raddr1  in   read port 1 address (rs)
//   raddr2  in   read port 2 address (rt)
//   rdata1  out  read port 1 data
//   rdata2  out  read port 2 data
//   hi_we   in   HI write enable
//   lo_we   in   LO write enable
//   hi_in   in   HI write data
//   lo_in   in   LO write data
//   hi_out  out  stored HI value
//   lo_out  out  stored LO value
// -----------------------------------------------------------------------------
module regfile_wb
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;

    // r0 is never written, so its storage stays at the reset value of zero.
    assign wr_en = we && (waddr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Forwarding is gated by rst_n so a write presented during reset cannot
    // leak to the read ports while the array is held at zero.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != ADDR_W'(REG_ZERO)) begin
            if (BYPASS && rst_n && wr_en && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != ADDR_W'(REG_ZERO)) begin
            if (BYPASS && rst_n && wr_en && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk    (clk),
        .rst_n  (rst_n),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .hi_in  (hi_in),
        .lo_in  (lo_in),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

endmodule : regfile_wb

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- General-purpose register file for the 54-instruction MIPS CPU: 32 x 32-bit GPRs plus the HI/LO pair.
- Sits directly downstream of the 5-bit destination-select mux. The mux output (rt or rd) drives `waddr` here.
- Two combinational read ports feed the ALU and branch-compare paths.
- One synchronous write port serves GPR writeback. A separate HI/LO write path serves mult, multu, div, divu, mthi and mtlo.

Parameters:
- DATA_W, 32, width of every register and data port.
- ADDR_W, 5, GPR address width; register count = 2**ADDR_W.
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads return the stored value only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  GPR write enable.
- waddr  in  ADDR_W  GPR write address (from the destination-select mux).
- wdata  in  DATA_W  GPR write data.
- raddr1  in  ADDR_W  read port 1 address (rs).
- raddr2  in  ADDR_W  read port 2 address (rt).
- rdata1  out  DATA_W  read port 1 data.
- rdata2  out  DATA_W  read port 2 data.
- hi_we  in  1  HI write enable.
- lo_we  in  1  LO write enable.
- hi_in  in  DATA_W  HI write data.
- lo_in  in  DATA_W  LO write data.
- hi_out  out  DATA_W  current HI contents.
- lo_out  out  DATA_W  current LO contents.

Behaviour:

Reset
- rst_n low clears all 32 GPRs, HI and LO to 0 immediately, without waiting for clk.
- While rst_n is low: writes are ignored, rdata1/rdata2/hi_out/lo_out read 0.
- Deasserting rst_n takes effect at the next rising edge.
- Reset asserted in the same cycle as a pending write: the write is lost; state is 0.

GPR write
- On rising clk, if we=1 and waddr!=0: reg[waddr] <= wdata.
- Write latency is 1 cycle. The value is visible through the storage path from the next cycle.
- waddr=0 is always discarded, so reg[0] stays 0 permanently.

GPR read
- Combinational and zero latency: rdataN = (raddrN==0) ? 0 : reg[raddrN].
- BYPASS=1: if we=1, waddr!=0 and waddr==raddrN in the same cycle, rdataN = wdata (combinational forward).
- BYPASS=0: the old contents are returned until the edge.
- Both ports may address the same register, and both see the same value, including the bypassed value.
- raddrN=0 returns 0 even when we=1 and waddr=0, regardless of BYPASS.

HI/LO
- Independent registers, each with 1-cycle write latency on rising clk.
- hi_we and lo_we may be asserted together (mult/div result) or separately (mthi/mtlo).
- hi_out and lo_out always show the stored value; there is no bypass on HI/LO.
- A simultaneous GPR write and HI/LO write is legal; the two paths are fully independent.

Width rules
- No arithmetic is performed; addresses are unsigned indices.
- Every 5-bit address is a valid register, so there is no out-of-range case.

Decomposition:
- Shared package `mips_pkg`:
  - constants REG_ZERO=5'd0 and REG_RA=5'd31 (jal target, driven through the destination mux);
  - DATA_W and ADDR_W defaults.
- One sub-module, `hilo_reg`:
  - two DATA_W registers with separate enables and async active-low reset;
  - instantiated once inside regfile_wb.
- The GPR array and read/bypass logic stay in the top module.

Test Plan:
- Reset check: pulse rst_n low mid-cycle after writing 0xDEADBEEF to r5 -> rdata1 for r5 = 0 immediately, before any clk edge; hi_out = lo_out = 0.
- r0 protection: we=1, waddr=0, wdata=0xFFFFFFFF, then read raddr1=0 -> rdata1 = 0 in the write cycle and in every later cycle.
- Write then read: write 0x12345678 to r31 -> the next cycle, raddr1=raddr2=31 both return 0x12345678.
- Bypass (BYPASS=1): r8 holds 0x1; in one cycle we=1, waddr=8, wdata=0xA5A5A5A5, raddr2=8 -> rdata2 = 0xA5A5A5A5 in the same cycle.
- No bypass (BYPASS=0), same stimulus -> rdata2 = 0x1 in that cycle and 0xA5A5A5A5 the next.
- HI/LO independence:
  - hi_we=lo_we=1 with hi_in=0x1, lo_in=0x2, plus a GPR write of 0x3 to r4 -> after the edge, hi_out=0x1, lo_out=0x2, r4=0x3;
  - then lo_we only with lo_in=0x7 -> hi_out stays 0x1, lo_out=0x7.
